sseg_mux_driver: RTL

SSEG_MUX_DRIVER -- requirements
Module: sseg_mux_driver

---
 rtl/sseg_mux_driver.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/sseg_mux_driver.sv
// Multiplexed seven-segment driver: scans NUM_DIGITS active-low digits with a
// double-buffered display register. Define SSEG_LZB_EN for leading-zero blanking.
module sseg_mux_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    neg,
  input  logic                    load,
  input  logic                    enable,
  output logic [6:0]              segs,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    pending
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_TC  = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]    SEG_MINUS = 7'h3F;
  localparam logic [6:0]    SEG_BLANK = 7'h7F;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h18;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [PW-1:0]           presc;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] shadow_val;
  logic                    shadow_neg;
  logic [4*NUM_DIGITS-1:0] active_val;
  logic                    active_neg;
  logic                    tc;
  logic                    commit;
  logic [3:0]              nibble;
  logic [6:0]              digit_segs;
  logic [NUM_DIGITS-1:0]   an_next;

  assign tc     = (presc == PRESC_TC);
  assign commit = tc && (idx == IDX_LAST);

  // Scan timebase: runs regardless of enable so the digit phase never slips.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc <= '0;
      idx   <= '0;
    end else if (tc) begin
      presc <= '0;
      idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Double buffer: active only changes at the end of a frame, so no tearing.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow_val <= '0;
      shadow_neg <= 1'b0;
      active_val <= '0;
      active_neg <= 1'b0;
      pending    <= 1'b0;
    end else begin
      if (commit) begin
        active_val <= shadow_val;
        active_neg <= shadow_neg;
      end
      if (load) begin
        shadow_val <= value;
        shadow_neg <= neg;
        pending    <= 1'b1;
      end else if (commit) begin
        pending    <= 1'b0;
      end
    end
  end

  assign nibble = active_val[{idx, 2'b00} +: 4];

`ifdef SSEG_LZB_EN
  logic [IW-1:0] msd;
  logic [IW-1:0] minus_pos;

  always_comb begin
    msd = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (active_val[4*i +: 4] != 4'h0) msd = IW'(i);
    end
  end

  // Minus sits just left of the leading digit unless the display is full.
  assign minus_pos = (msd == IDX_LAST) ? IDX_LAST : msd + 1'b1;

  always_comb begin
    if (active_neg && (idx == minus_pos)) digit_segs = SEG_MINUS;
    else if (idx > msd)                   digit_segs = SEG_BLANK;
    else                                  digit_segs = hex7(nibble);
  end
`else
  always_comb begin
    if (active_neg && (idx == IDX_LAST)) digit_segs = SEG_MINUS;
    else                                 digit_segs = hex7(nibble);
  end
`endif

  always_comb begin
    an_next      = '1;
    an_next[idx] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      segs <= SEG_BLANK;
      an   <= '1;
    end else if (!enable) begin
      segs <= SEG_BLANK;
      an   <= '1;
    end else begin
      segs <= digit_segs;
      an   <= an_next;
    end
  end

endmodule
